// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//
// Single-entry ID/EX pipeline register with operand forwarding.
// The stage captures a decoded instruction from the decode stage, holds it
// until the EX stage consumes it, and presents ALU operands after
// MEM/WB forwarding and immediate selection.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid / id_ready             decode-side handshake
//   id_rs_data, id_rt_data, id_imm  operand values from decode
//   id_rs_addr, id_rt_addr,
//   id_rd_addr                      source/destination register numbers
//   id_alu_src, id_alu_control,
//   id_reg_write                    control fields from decode
//   flush                           squash held and incoming instruction
//   mem_reg_write, mem_rd,
//   mem_result                      MEM-stage forwarding source
//   wb_reg_write, wb_rd, wb_result  WB-stage forwarding source
//   ex_ready / ex_valid             EX-side handshake
//   alu_a, alu_b, alu_ctl           ALU operands and op code
//   ex_store_data                   forwarded rt value
//   ex_rd, ex_reg_write             destination register and write enable
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_alu_src,
    input  logic [2:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [REG_AW-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic              alu_src_q,   alu_src_d;
    logic [2:0]        alu_ctl_q,   alu_ctl_d;
    logic              reg_write_q, reg_write_d;

    logic              load;
    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;

    // Forwarding select: MEM has priority over WB; register 0 never forwards.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] reg_val,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [DATA_W-1:0] m_val,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd,
        input logic [DATA_W-1:0] w_val
    );
        logic [DATA_W-1:0] r;
        r = reg_val;
        if (addr != '0) begin
            if (m_we && (m_rd == addr)) begin
                r = m_val;
            end else if (w_we && (w_rd == addr)) begin
                r = w_val;
            end
        end
        return r;
    endfunction

    // A flush also opens the stage so the decode side is never blocked by
    // an instruction that is about to be squashed anyway.
    assign id_ready = !valid_q || ex_ready || flush;
    assign load     = id_valid && id_ready && !flush;

    always_comb begin
        valid_d     = valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_src_d   = alu_src_q;
        alu_ctl_d   = alu_ctl_q;
        reg_write_d = reg_write_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end

        if (load) begin
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            alu_src_d   = id_alu_src;
            alu_ctl_d   = id_alu_control;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            alu_src_q   <= 1'b0;
            alu_ctl_q   <= 3'b000;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_src_q   <= alu_src_d;
            alu_ctl_q   <= alu_ctl_d;
            reg_write_q <= reg_write_d;
        end
    end

    // Forwarding is evaluated every cycle from the held addresses, so a
    // stalled instruction picks up results that arrive while it waits.
    always_comb begin
        fa = fwd_sel(rs_addr_q, rs_data_q, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
        fb = fwd_sel(rt_addr_q, rt_data_q, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
    end

    // Outputs are forced to zero while the stage is empty.
    always_comb begin
        ex_valid      = valid_q;
        alu_a         = '0;
        alu_b         = '0;
        alu_ctl       = 3'b000;
        ex_store_data = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        if (valid_q) begin
            alu_a         = fa;
            alu_b         = alu_src_q ? imm_q : fb;
            alu_ctl       = alu_ctl_q;
            ex_store_data = fb;
            ex_rd         = rd_addr_q;
            ex_reg_write  = reg_write_q;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_alu_src;
    logic [2:0]  id_alu_control;
    logic        id_reg_write;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_ctl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] rs_d, input logic [31:0] rt_d,
                             input logic [31:0] imm, input logic [4:0] rs_a,
                             input logic [4:0] rt_a, input logic [4:0] rd_a,
                             input logic src, input logic [2:0] ctl, input logic we);
        id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
        id_rs_addr = rs_a; id_rt_addr = rt_a; id_rd_addr = rd_a;
        id_alu_src = src; id_alu_control = ctl; id_reg_write = we;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        set_instr(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0);
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
        #2;
        // Reset state
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctl", {29'b0, alu_ctl}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_id_ready", {31'b0, id_ready}, 32'd1);

        // Basic load: 5 ADD 7
        set_instr(32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd4, 1'b0, 3'b010, 1'b1);
        id_valid = 1'b1; ex_ready = 1'b1;
        tick();
        chk("load_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("load_alu_a", alu_a, 32'd5);
        chk("load_alu_b", alu_b, 32'd7);
        chk("load_alu_ctl", {29'b0, alu_ctl}, 32'd2);
        chk("load_ex_rd", {27'b0, ex_rd}, 32'd4);
        chk("load_reg_write", {31'b0, ex_reg_write}, 32'd1);
        chk("load_store", ex_store_data, 32'd7);

        // Forwarding on held rs=3, rt=0, undefined op code 101
        set_instr(32'h1111, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 1'b0, 3'b101, 1'b0);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hAAAA;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h5555;
        #1;
        chk("fwd_mem_prio", alu_a, 32'hAAAA);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", alu_a, 32'h5555);
        chk("undef_ctl", {29'b0, alu_ctl}, 32'd5);
        wb_rd = 5'd0; wb_result = 32'hFFFF;
        #1;
        chk("fwd_none", alu_a, 32'h1111);
        chk("r0_no_fwd_b", alu_b, 32'd0);
        tick();
        chk("stall_hold_valid", {31'b0, ex_valid}, 32'd1);
        chk("stall_hold_a", alu_a, 32'h1111);

        // Immediate select with rt=0 and a WB write to r0 pending
        set_instr(32'd1, 32'd0, 32'hFFFF_FFFC, 5'd1, 5'd0, 5'd9, 1'b1, 3'b010, 1'b1);
        id_valid = 1'b1; ex_ready = 1'b1;
        tick();
        chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        chk("imm_store_r0", ex_store_data, 32'd0);
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;

        // rt forwarding from MEM
        set_instr(32'd1, 32'd9, 32'h0, 5'd1, 5'd6, 5'd9, 1'b0, 3'b110, 1'b1);
        mem_reg_write = 1'b1; mem_rd = 5'd6; mem_result = 32'h1234_5678;
        tick();
        chk("fwd_rt_alu_b", alu_b, 32'h1234_5678);
        chk("fwd_rt_store", ex_store_data, 32'h1234_5678);
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;

        // Stall: hold A for 3 cycles while B waits
        set_instr(32'h10, 32'h0, 32'h0, 5'd1, 5'd2, 5'd10, 1'b0, 3'b000, 1'b1);
        tick();
        set_instr(32'h20, 32'h0, 32'h0, 5'd1, 5'd2, 5'd11, 1'b0, 3'b001, 1'b1);
        ex_ready = 1'b0;
        #1;
        chk("stall_id_ready", {31'b0, id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_a_held", alu_a, 32'h10);
        end
        chk("stall_rd_held", {27'b0, ex_rd}, 32'd10);
        ex_ready = 1'b1;
        #1;
        chk("release_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("b2b_valid", {31'b0, ex_valid}, 32'd1);
        chk("b2b_alu_a", alu_a, 32'h20);
        chk("b2b_ctl", {29'b0, alu_ctl}, 32'd1);

        // Drain to EMPTY: outputs zeroed
        id_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, ex_valid}, 32'd0);
        chk("drain_alu_a", alu_a, 32'd0);
        chk("drain_ex_rd", {27'b0, ex_rd}, 32'd0);
        chk("drain_reg_write", {31'b0, ex_reg_write}, 32'd0);

        // Flush overrides load while FULL and stalled
        set_instr(32'h30, 32'h31, 32'h0, 5'd1, 5'd2, 5'd12, 1'b0, 3'b111, 1'b1);
        id_valid = 1'b1;
        tick();
        set_instr(32'h40, 32'h41, 32'h0, 5'd1, 5'd2, 5'd13, 1'b0, 3'b010, 1'b1);
        ex_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_alu_b", alu_b, 32'd0);
        chk("flush_alu_ctl", {29'b0, alu_ctl}, 32'd0);

        // Asynchronous reset while FULL and stalled
        set_instr(32'h50, 32'h51, 32'h0, 5'd1, 5'd2, 5'd14, 1'b0, 3'b010, 1'b1);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("async_rst_alu_a", alu_a, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rerst_id_ready", {31'b0, id_ready}, 32'd1);
        set_instr(32'h60, 32'h61, 32'h0, 5'd1, 5'd2, 5'd15, 1'b0, 3'b000, 1'b0);
        id_valid = 1'b1;
        tick();
        chk("first_load_after_rst", alu_a, 32'h60);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001: Parameter DATA_W, default 32, datapath width of operands and results; only 32 is supported.
REQ-002: Parameter REG_AW, default 5, register-address width.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: id_valid  input  1  decode stage presents a valid instruction.
REQ-006: id_ready  output  1  stage accepts the instruction this cycle.
REQ-007: id_rs_data, id_rt_data  input  32 each  register-file read values.
REQ-008: id_imm  input  32  sign-extended immediate.
REQ-009: id_rs_addr, id_rt_addr, id_rd_addr  input  5 each  source/destination register numbers.
REQ-010: id_alu_src  input  1  1 selects id_imm as ALU operand b, 0 selects rt.
REQ-011: id_alu_control  input  3  ALU op code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
REQ-012: id_reg_write  input  1  instruction writes id_rd_addr.
REQ-013: flush  input  1  synchronous squash of the held and incoming instruction.
REQ-014: mem_reg_write, mem_rd, mem_result  input  1/5/32  MEM-stage forwarding source.
REQ-015: wb_reg_write, wb_rd, wb_result  input  1/5/32  WB-stage forwarding source.
REQ-016: ex_ready  input  1  ALU/EX stage consumes the held instruction this cycle.
REQ-017: ex_valid  output  1  held instruction is valid.
REQ-018: alu_a, alu_b  output  32 each  ALU operands after forwarding and immediate select.
REQ-019: alu_ctl  output  3  registered ALU op code.
REQ-020: ex_store_data  output  32  forwarded rt value (store data).
REQ-021: ex_rd, ex_reg_write  output  5/1  registered destination and write enable.

Function
REQ-022: Stage SHALL be a single-entry pipeline register: states EMPTY (ex_valid=0) and FULL (ex_valid=1).
REQ-023: id_ready SHALL equal (!ex_valid | ex_ready | flush), combinationally.
REQ-024: Load occurs when id_valid & id_ready & !flush; all id_* fields are captured; ex_valid=1 next cycle (1-cycle latency).
REQ-025: EMPTY->FULL on load; FULL->FULL on load with ex_ready (back-to-back, no bubble); FULL->EMPTY on ex_ready without load; FULL holds all registered fields unchanged while !ex_ready.
REQ-026: flush SHALL force ex_valid=0 next cycle, overriding a simultaneous load and ex_ready; the incoming instruction is discarded.
REQ-027: Forwarded rs (fa) SHALL be: mem_result if mem_reg_write & mem_rd==rs_addr & rs_addr!=0; else wb_result if wb_reg_write & wb_rd==rs_addr & rs_addr!=0; else registered rs_data. MEM priority over WB.
REQ-028: Forwarded rt (fb) SHALL follow the same rule using rt_addr.
REQ-029: Forwarding SHALL be combinational from the registered addresses and current mem_*/wb_* inputs, re-evaluated every cycle while stalled.
REQ-030: alu_a = fa; alu_b = alu_src ? imm : fb; ex_store_data = fb.
REQ-031: Register 0 SHALL never be forwarded; its operand is registered data unchanged.
REQ-032: While ex_valid=0, alu_a, alu_b, ex_store_data SHALL be 0, alu_ctl=000, ex_reg_write=0, ex_rd=0.
REQ-033: alu_ctl SHALL pass the captured code unmodified, including undefined codes.

Reset
REQ-034: rst_n low SHALL immediately clear ex_valid and every registered field to 0, independent of clk, including mid-stall.
REQ-035: After rst_n deasserts, id_ready=1 and first load occurs on the first qualifying rising edge.

Verification
REQ-036: Load rs_data=5, rt_data=7, alu_control=010, no hazards, ex_ready=1 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_ctl=010.
REQ-037: Held rs_addr=3; mem_reg_write=1, mem_rd=3, mem_result=0xAAAA; wb_reg_write=1, wb_rd=3, wb_result=0x5555 -> alu_a=0xAAAA; drop mem_reg_write -> alu_a=0x5555 same cycle.
REQ-038: rt_addr=0, wb_rd=0, wb_reg_write=1, wb_result=0xFFFF, rt_data=0 -> alu_b=0; alu_src=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC, ex_store_data=0.
REQ-039: FULL, ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, fields held; ex_ready=1 -> next instruction loads same edge, ex_valid stays 1.
REQ-040: flush=1 with id_valid=1, ex_ready=0 -> next cycle ex_valid=0, outputs 0; rst_n pulsed low mid-FULL -> ex_valid=0 before next clk edge.
